irq_ctrl: RTL and testbench

Interrupt and exception sequencer for the summer single-cycle MIPS CPU. Latches peripheral interrupt requests, masks and prioritises them, and detects undefined instructions. On the retiring instruction it overrides the control unit to vector the PC into kernel space and save the return address in $26. It tracks user/kernel mode and releases kernel mode on `jr $26`.

---
 rtl/irq_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_irq_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// -----------------------------------------------------------------------------
// irq_ctrl: interrupt and exception sequencer for the single-cycle MIPS CPU.
//
// Purpose
//   Latches peripheral interrupt requests on rising edges, masks them, and
//   picks the lowest-index eligible source. Optionally detects undefined
//   instructions. On the retiring instruction it raises `trap`. The CPU then
//   squashes the instruction's writes, stores `epc` in $26, and jumps to
//   `vector`. The block also tracks user/kernel mode and leaves kernel mode
//   when `jr $26` retires.
//
// Build option
//   IRQ_CTRL_ILLOP_EN : when defined, undefined opcode/funct encodings trap to
//                       ILLOP_ADDR. When undefined, no instruction is illegal
//                       and only interrupts can trap. The ports are the same
//                       in both builds.
//
// Ports
//   clk         in   single clock
//   reset       in   synchronous, active-low
//   step        in   an instruction retires this cycle
//   PC          in   address of the retiring instruction
//   OpCode      in   instruction [31:26]
//   Funct       in   instruction [5:0]
//   Rs          in   instruction [25:21]
//   irq_src     in   level interrupt requests from peripherals
//   mask_we     in   load the mask register with mask_wdata
//   mask_wdata  in   new mask (1 = source enabled)
//   trap        out  override control this cycle
//   vector      out  trap target (0 when no trap)
//   epc         out  return address to write into $26
//   irq_ack     out  one-hot acknowledge pulse to the serviced source
//   irq_id      out  index of the serviced source
//   kernel      out  CPU is in kernel mode (FSM state or kernel-space PC)
//   mask        out  current mask register
// -----------------------------------------------------------------------------
module irq_ctrl #(
    parameter int          NUM_SRC    = 4,
    parameter logic [31:0] ILLOP_ADDR = 32'h8000_0004,
    parameter logic [31:0] XADR_ADDR  = 32'h8000_0008
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               step,
    input  logic [31:0]        PC,
    input  logic [5:0]         OpCode,
    input  logic [5:0]         Funct,
    input  logic [4:0]         Rs,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               mask_we,
    input  logic [NUM_SRC-1:0] mask_wdata,
    output logic               trap,
    output logic [31:0]        vector,
    output logic [31:0]        epc,
    output logic [NUM_SRC-1:0] irq_ack,
    output logic [2:0]         irq_id,
    output logic               kernel,
    output logic [NUM_SRC-1:0] mask
);

    typedef enum logic {
        ST_USER   = 1'b0,
        ST_KERNEL = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] prev_q, prev_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;

    logic               illop;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] win_onehot;
    logic [2:0]         win_idx;
    logic               win_found;
    logic               user_slot;
    logic               is_jr26;

    // ------------------------------------------------------------------
    // Instruction decode
    // ------------------------------------------------------------------
`ifdef IRQ_CTRL_ILLOP_EN
    always_comb begin
        illop = 1'b1;
        if (OpCode == 6'h00) begin
            case (Funct)
                6'h00, 6'h02, 6'h03, 6'h08, 6'h09,
                6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                6'h2A, 6'h2B: illop = 1'b0;
                default:      illop = 1'b1;
            endcase
        end else if ((OpCode <= 6'h0C) || (OpCode == 6'h0F) ||
                     (OpCode == 6'h23) || (OpCode == 6'h2B)) begin
            illop = 1'b0;
        end
    end
`else
    assign illop = 1'b0;
`endif

    assign is_jr26 = (OpCode == 6'h00) && (Funct == 6'h08) && (Rs == 5'd26);

    // ------------------------------------------------------------------
    // Arbitration: the lowest-index source of pend & mask wins.
    // The loop walks downward, so the last hit it keeps is the lowest index.
    // ------------------------------------------------------------------
    assign eligible  = pend_q & mask_q;
    assign win_found = |eligible;

    always_comb begin
        win_idx = 3'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_idx = 3'(i);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_win
            assign win_onehot[gi] = eligible[gi] && (win_idx == 3'(gi));
        end
    endgenerate

    // A trap can only be taken on a retiring user-mode instruction at a
    // user address. Holding reset suppresses every trap, so reset never acks.
    assign user_slot = reset && step && (state_q == ST_USER) && !PC[31];

    // ------------------------------------------------------------------
    // FSM: state register / next-state logic / output logic
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_USER;
            pend_q  <= '0;
            prev_q  <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            prev_q  <= prev_d;
            mask_q  <= mask_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_USER:   if (trap)            state_d = ST_KERNEL;
            ST_KERNEL: if (step && is_jr26) state_d = ST_USER;
            default:                        state_d = ST_USER;
        endcase
    end

    always_comb begin
        trap    = 1'b0;
        vector  = 32'h0;
        epc     = 32'h0;
        irq_ack = '0;
        irq_id  = 3'd0;
        if (user_slot) begin
            if (illop) begin
                // The undefined instruction is skipped on return.
                trap   = 1'b1;
                vector = ILLOP_ADDR;
                epc    = PC + 32'd4;
            end else if (win_found) begin
                // The instruction is squashed and re-executed on return.
                trap    = 1'b1;
                vector  = XADR_ADDR;
                epc     = PC;
                irq_ack = win_onehot;
                irq_id  = win_idx;
            end
        end
    end

    assign kernel = (state_q == ST_KERNEL) || PC[31];
    assign mask   = mask_q;

    // ------------------------------------------------------------------
    // Pending, edge-sample and mask updates.
    // A new edge in the ack cycle overrides the clear, so it is not lost.
    // ------------------------------------------------------------------
    always_comb begin
        pend_d = (pend_q & ~irq_ack) | (irq_src & ~prev_q);
        prev_d = irq_src;
        mask_d = mask_we ? mask_wdata : mask_q;
    end

endmodule

// File: tb/tb_irq_ctrl.sv
module tb_irq_ctrl;

    localparam int NUM_SRC = 4;
`ifdef IRQ_CTRL_ILLOP_EN
    localparam bit ILLOP_EN = 1'b1;
`else
    localparam bit ILLOP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        step;
    logic [31:0] pc;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs;
    logic [3:0]  irq_src;
    logic        mask_we;
    logic [3:0]  mask_wdata;
    logic        trap;
    logic [31:0] vector, epc;
    logic [3:0]  irq_ack;
    logic [2:0]  irq_id;
    logic        kernel;
    logic [3:0]  mask;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    irq_ctrl #(.NUM_SRC(NUM_SRC)) dut (
        .clk(clk), .reset(reset), .step(step), .PC(pc), .OpCode(opcode),
        .Funct(funct), .Rs(rs), .irq_src(irq_src), .mask_we(mask_we),
        .mask_wdata(mask_wdata), .trap(trap), .vector(vector), .epc(epc),
        .irq_ack(irq_ack), .irq_id(irq_id), .kernel(kernel), .mask(mask)
    );

    // ---------------- behavioural reference model ----------------
    bit [3:0]  m_pend, m_prev, m_mask;
    bit        m_kern;
    bit        e_trap, e_kern;
    bit [31:0] e_vec, e_epc;
    bit [3:0]  e_ack;
    bit [2:0]  e_id;

    function automatic bit is_legal(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00)
            return fn inside {6'h00, 6'h02, 6'h03, 6'h08, 6'h09, [6'h20:6'h27], 6'h2A, 6'h2B};
        return op inside {[6'h01:6'h0C], 6'h0F, 6'h23, 6'h2B};
    endfunction

    task automatic model_eval();
        bit [3:0] elig;
        e_trap = 0; e_vec = 0; e_epc = 0; e_ack = 0; e_id = 0;
        e_kern = m_kern || pc[31];
        if (reset && step && !m_kern && !pc[31]) begin
            elig = m_pend & m_mask;
            if (ILLOP_EN && !is_legal(opcode, funct)) begin
                e_trap = 1; e_vec = 32'h8000_0004; e_epc = pc + 32'd4;
            end else if (elig != 0) begin
                e_trap = 1; e_vec = 32'h8000_0008; e_epc = pc;
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (elig[i]) begin
                        e_id = 3'(i); e_ack = 4'(1 << i);
                        break;
                    end
                end
            end
        end
    endtask

    task automatic model_commit();
        if (!reset) begin
            m_pend = 0; m_prev = 0; m_mask = 0; m_kern = 0;
        end else begin
            if (e_trap) m_kern = 1;
            else if (m_kern && step && opcode == 0 && funct == 6'h08 && rs == 26) m_kern = 0;
            m_pend = (m_pend & ~e_ack) | (irq_src & ~m_prev);
            m_prev = irq_src;
            if (mask_we) m_mask = mask_wdata;
        end
    endtask

    // ---------------- stimulus plumbing ----------------
    task automatic drive(input logic s, input logic [31:0] p, input logic [5:0] op,
                         input logic [5:0] fn, input logic [4:0] r, input logic [3:0] src,
                         input logic we, input logic [3:0] wd);
        step = s; pc = p; opcode = op; funct = fn; rs = r;
        irq_src = src; mask_we = we; mask_wdata = wd;
        model_eval();
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 0;
        for (int c = 0; c < 2; c++) begin
            drive(1, 32'h40, 0, 0, 0, 4'b0000, 0, 0);
            tick();
        end
        drive(1, 32'h40, 0, 0, 0, 4'b0000, 0, 0);
        n_checks++; if (trap !== 1'b0) begin n_fail++; $display("FAIL reset_trap: got %b want 0", trap); end
        n_checks++; if (vector !== 32'h0 || epc !== 32'h0) begin n_fail++; $display("FAIL reset_vec_epc: got %h/%h want 0/0", vector, epc); end
        n_checks++; if (irq_ack !== 4'b0 || irq_id !== 3'd0) begin n_fail++; $display("FAIL reset_ack_id: got %b/%0d want 0/0", irq_ack, irq_id); end
        n_checks++; if (mask !== 4'b0 || kernel !== 1'b0) begin n_fail++; $display("FAIL reset_mask_kernel: got %b/%b want 0/0", mask, kernel); end
        reset = 1;
        $display("test_reset done");
    endtask

    task automatic test_enable();
        drive(0, 32'h3C, 0, 0, 0, 4'b0000, 1, 4'b0001); tick();
        drive(1, 32'h40, 0, 0, 0, 4'b0001, 0, 0);
        n_checks++; if (trap !== 1'b0) begin n_fail++; $display("FAIL enable_no_early_trap: got %b want 0", trap); end
        tick();
        drive(1, 32'h40, 0, 0, 0, 4'b0001, 0, 0);
        n_checks++; if (trap !== 1'b1 || vector !== 32'h8000_0008 || epc !== 32'h40)
            begin n_fail++; $display("FAIL enable_trap: got %b %h %h want 1 80000008 00000040", trap, vector, epc); end
        n_checks++; if (irq_ack !== 4'b0001 || irq_id !== 3'd0)
            begin n_fail++; $display("FAIL enable_ack: got %b/%0d want 0001/0", irq_ack, irq_id); end
        tick();
        drive(1, 32'h44, 0, 0, 0, 4'b0001, 0, 0);
        n_checks++; if (kernel !== 1'b1 || trap !== 1'b0) begin n_fail++; $display("FAIL enable_kernel: got k=%b t=%b want k=1 t=0", kernel, trap); end
        tick();
        drive(1, 32'h48, 0, 6'h08, 26, 4'b0001, 0, 0); tick();
        drive(1, 32'h40, 0, 0, 0, 4'b0001, 0, 0);
        n_checks++; if (kernel !== 1'b0 || trap !== 1'b0) begin n_fail++; $display("FAIL enable_return: got k=%b t=%b want 0 0", kernel, trap); end
        tick();
        $display("test_enable done");
    endtask

    task automatic test_priority();
        drive(0, 32'h200, 0, 0, 0, 4'b0000, 1, 4'b0110); tick();
        drive(0, 32'h200, 0, 0, 0, 4'b1110, 0, 0); tick();
        drive(1, 32'h200, 0, 0, 0, 4'b1110, 0, 0);
        n_checks++; if (trap !== 1'b1 || irq_ack !== 4'b0010 || irq_id !== 3'd1)
            begin n_fail++; $display("FAIL prio_first: got t=%b ack=%b id=%0d want 1 0010 1", trap, irq_ack, irq_id); end
        tick();
        drive(1, 32'h8000_0008, 0, 6'h08, 26, 4'b1110, 0, 0);
        n_checks++; if (trap !== 1'b0) begin n_fail++; $display("FAIL prio_kernel_notrap: got %b want 0", trap); end
        tick();
        drive(1, 32'h200, 0, 0, 0, 4'b1110, 0, 0);
        n_checks++; if (trap !== 1'b1 || irq_ack !== 4'b0100 || irq_id !== 3'd2)
            begin n_fail++; $display("FAIL prio_second: got t=%b ack=%b id=%0d want 1 0100 2", trap, irq_ack, irq_id); end
        tick();
        drive(1, 32'h8000_0010, 0, 6'h08, 26, 4'b1110, 0, 0); tick();
        drive(1, 32'h200, 0, 0, 0, 4'b1110, 0, 0);
        n_checks++; if (trap !== 1'b0 || irq_ack !== 4'b0000) begin n_fail++; $display("FAIL prio_masked_src3: got t=%b ack=%b want 0 0000", trap, irq_ack); end
        tick();
        $display("test_priority done");
    endtask

    task automatic test_illop();
        drive(0, 32'h100, 0, 0, 0, 4'b0000, 1, 4'b0001); tick();
        drive(0, 32'h100, 0, 0, 0, 4'b0001, 0, 0); tick();
        drive(1, 32'h100, 6'h3F, 0, 0, 4'b0001, 0, 0);
`ifdef IRQ_CTRL_ILLOP_EN
        n_checks++; if (trap !== 1'b1 || vector !== 32'h8000_0004 || epc !== 32'h104 || irq_ack !== 4'b0)
            begin n_fail++; $display("FAIL illop_trap: got %b %h %h %b want 1 80000004 00000104 0000", trap, vector, epc, irq_ack); end
        tick();
        drive(1, 32'h8000_0004, 0, 6'h08, 26, 4'b0001, 0, 0); tick();
        drive(1, 32'h104, 0, 0, 0, 4'b0001, 0, 0);
        n_checks++; if (trap !== 1'b1 || irq_ack !== 4'b0001)
            begin n_fail++; $display("FAIL illop_irq_kept: got t=%b ack=%b want 1 0001", trap, irq_ack); end
`else
        n_checks++; if (trap !== 1'b1 || vector !== 32'h8000_0008 || epc !== 32'h100 || irq_ack !== 4'b0001)
            begin n_fail++; $display("FAIL illop_off_irq: got %b %h %h %b want 1 80000008 00000100 0001", trap, vector, epc, irq_ack); end
`endif
        tick();
        drive(1, 32'h8000_0008, 0, 6'h08, 26, 4'b0001, 0, 0); tick();
        // No pending irq: only an enabled illegal-op check can trap here.
        drive(1, 32'h120, 6'h3F, 0, 0, 4'b0001, 0, 0);
`ifdef IRQ_CTRL_ILLOP_EN
        n_checks++; if (trap !== 1'b1 || vector !== 32'h8000_0004) begin n_fail++; $display("FAIL illop_alone: got %b %h want 1 80000004", trap, vector); end
        tick();
        drive(1, 32'h8000_0004, 0, 6'h08, 26, 4'b0001, 0, 0);
        n_checks++; if (kernel !== 1'b1) begin n_fail++; $display("FAIL illop_kernel: got %b want 1", kernel); end
`else
        n_checks++; if (trap !== 1'b0 || kernel !== 1'b0) begin n_fail++; $display("FAIL illop_off_nop: got t=%b k=%b want 0 0", trap, kernel); end
        tick();
        drive(1, 32'h124, 0, 0, 0, 4'b0001, 0, 0);
        n_checks++; if (kernel !== 1'b0) begin n_fail++; $display("FAIL illop_off_kernel: got %b want 0", kernel); end
`endif
        tick();
        $display("test_illop done");
    endtask

    task automatic test_stall();
        drive(0, 32'h300, 0, 0, 0, 4'b0000, 0, 0); tick();
        drive(0, 32'h300, 0, 0, 0, 4'b0001, 0, 0); tick();
        for (int c = 0; c < 3; c++) begin
            drive(0, 32'h300, 0, 0, 0, 4'b0001, 0, 0);
            n_checks++; if (trap !== 1'b0 || irq_ack !== 4'b0) begin n_fail++; $display("FAIL stall_wait%0d: got t=%b ack=%b want 0 0000", c, trap, irq_ack); end
            tick();
        end
        drive(1, 32'h300, 0, 0, 0, 4'b0001, 0, 0);
        n_checks++; if (trap !== 1'b1 || irq_ack !== 4'b0001) begin n_fail++; $display("FAIL stall_release: got t=%b ack=%b want 1 0001", trap, irq_ack); end
        tick();
        drive(1, 32'h8000_0008, 0, 6'h08, 26, 4'b0001, 0, 0); tick();
        drive(0, 32'h300, 0, 0, 0, 4'b0000, 0, 0); tick();
        drive(0, 32'h300, 0, 0, 0, 4'b0001, 0, 0); tick();
        drive(1, 32'h8000_0010, 0, 0, 0, 4'b0001, 0, 0);
        n_checks++; if (trap !== 1'b0 || kernel !== 1'b1) begin n_fail++; $display("FAIL kernel_guard: got t=%b k=%b want 0 1", trap, kernel); end
        tick();
        drive(1, 32'h314, 0, 0, 0, 4'b0001, 0, 0);
        n_checks++; if (trap !== 1'b1 || epc !== 32'h314) begin n_fail++; $display("FAIL guard_then_trap: got t=%b epc=%h want 1 00000314", trap, epc); end
        tick();
        drive(1, 32'h8000_0008, 0, 6'h08, 26, 4'b0001, 0, 0); tick();
        $display("test_stall done");
    endtask

    task automatic test_midreset();
        drive(0, 32'h400, 0, 0, 0, 4'b0000, 1, 4'b1111); tick();
        drive(0, 32'h400, 0, 0, 0, 4'b0011, 0, 0); tick();
        drive(1, 32'h400, 0, 0, 0, 4'b0011, 0, 0); tick();
        reset = 0;
        drive(1, 32'h404, 0, 0, 0, 4'b0011, 0, 0);
        n_checks++; if (trap !== 1'b0 || irq_ack !== 4'b0) begin n_fail++; $display("FAIL midreset_no_ack: got t=%b ack=%b want 0 0000", trap, irq_ack); end
        tick();
        reset = 1;
        drive(1, 32'h404, 0, 0, 0, 4'b0011, 0, 0);
        n_checks++; if (kernel !== 1'b0 || mask !== 4'b0 || trap !== 1'b0)
            begin n_fail++; $display("FAIL midreset_state: got k=%b mask=%b t=%b want 0 0000 0", kernel, mask, trap); end
        tick();
        drive(0, 32'h404, 0, 0, 0, 4'b0000, 0, 0); tick();
        $display("test_midreset done");
    endtask

    task automatic test_random();
        logic        r_rst, r_step, r_we;
        logic [31:0] r_pc;
        logic [5:0]  r_op, r_fn;
        logic [4:0]  r_rs;
        logic [3:0]  r_src, r_wd;
        int          sel;
        r_src = irq_src;
        for (int c = 0; c < 300; c++) begin
            r_rst  = ($urandom_range(0, 99) != 0);
            r_step = ($urandom_range(0, 3) != 0);
            r_pc   = {($urandom_range(0, 5) == 0), 29'($urandom), 2'b00};
            r_rs   = 5'($urandom);
            sel    = $urandom_range(0, 9);
            case (sel)
                0, 1, 2: begin r_op = 6'h00; r_fn = 6'h20; end
                3, 4:    begin r_op = 6'h00; r_fn = 6'h08; r_rs = 5'd26; end
                5:       begin r_op = 6'h3F; r_fn = 6'($urandom); end
                6, 7:    begin r_op = 6'($urandom); r_fn = 6'($urandom); end
                default: begin r_op = 6'h23; r_fn = 6'($urandom); end
            endcase
            // Keep undefined encodings at user addresses only.
            if (!is_legal(r_op, r_fn)) r_pc[31] = 1'b0;
            if ($urandom_range(0, 9) < 3) r_src[$urandom_range(0, 3)] ^= 1'b1;
            r_we = ($urandom_range(0, 9) == 0);
            r_wd = 4'($urandom);
            reset = r_rst;
            drive(r_step, r_pc, r_op, r_fn, r_rs, r_src, r_we, r_wd);
            n_checks++; if (trap !== e_trap) begin n_fail++; $display("FAIL rnd%0d_trap: got %b want %b", c, trap, e_trap); end
            n_checks++; if (vector !== e_vec) begin n_fail++; $display("FAIL rnd%0d_vector: got %h want %h", c, vector, e_vec); end
            n_checks++; if (epc !== e_epc) begin n_fail++; $display("FAIL rnd%0d_epc: got %h want %h", c, epc, e_epc); end
            n_checks++; if (irq_ack !== e_ack) begin n_fail++; $display("FAIL rnd%0d_ack: got %b want %b", c, irq_ack, e_ack); end
            n_checks++; if (e_trap && irq_id !== e_id) begin n_fail++; $display("FAIL rnd%0d_id: got %0d want %0d", c, irq_id, e_id); end
            n_checks++; if (kernel !== e_kern) begin n_fail++; $display("FAIL rnd%0d_kernel: got %b want %b", c, kernel, e_kern); end
            n_checks++; if (mask !== m_mask) begin n_fail++; $display("FAIL rnd%0d_mask: got %b want %b", c, mask, m_mask); end
            tick();
        end
        reset = 1;
        $display("test_random done");
    endtask

    initial begin
        reset = 0; step = 0; pc = 0; opcode = 0; funct = 0; rs = 0;
        irq_src = 0; mask_we = 0; mask_wdata = 0;
        m_pend = 0; m_prev = 0; m_mask = 0; m_kern = 0;
        @(posedge clk); #1;
        test_reset();
        test_enable();
        test_priority();
        test_illop();
        test_stall();
        test_midreset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
